serial_deserializer: RTL and testbench



---
 rtl/deser_pkg.sv | 6 +
 rtl/deser_bit_counter.sv | 36 +++
 rtl/serial_deserializer.sv | 114 +++++++++++
 tb/tb_serial_deserializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types for the serial word deserializer.
package deser_pkg;

    typedef enum logic {S_FILL, S_STALL} deser_state_t;

endpackage

// File: rtl/deser_bit_counter.sv
// Saturating up-counter 0..MAX with synchronous clear (clear wins over increment).
// Single-cycle update; no flow control of its own.
module deser_bit_counter #(
    parameter int MAX = 32,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CW'(MAX))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out word assembler with shift register + output register double buffering.
// A completed word appears on data_out the edge its last bit is accepted; bit_ready drops only while a second word waits.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int LEN       = 32,
    parameter int MSB_FIRST = 1,
    parameter int CW        = $clog2(LEN + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           bit_in,
    input  logic           bit_valid,
    output logic           bit_ready,
    output logic [LEN-1:0] data_out,
    output logic           data_valid,
    input  logic           data_ready,
    output logic [CW-1:0]  bit_count
);

    deser_state_t   state_q, state_d;
    logic [LEN-1:0] shreg_q, shreg_d;
    logic [LEN-1:0] dout_q, dout_d;
    logic           dvld_q, dvld_d;
    logic [LEN-1:0] word_w;
    logic           bit_acc, word_acc, last_bit;
    logic           cnt_inc, cnt_clr;

    if (MSB_FIRST != 0) begin : g_msb
        assign word_w = {shreg_q[LEN-2:0], bit_in};
    end else begin : g_lsb
        assign word_w = {bit_in, shreg_q[LEN-1:1]};
    end

    assign bit_ready = (state_q == S_FILL) && !reset;
    assign bit_acc   = bit_valid && bit_ready;
    assign word_acc  = dvld_q && data_ready;
    assign last_bit  = (bit_count == CW'(LEN - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        dvld_d  = dvld_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (word_acc) begin
            dvld_d = 1'b0;
        end
        // clear drops any coincident bit and any stalled word, but leaves the output register alone
        if (clear) begin
            shreg_d = '0;
            cnt_clr = 1'b1;
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (bit_acc) begin
                        shreg_d = word_w;
                        if (!last_bit) begin
                            cnt_inc = 1'b1;
                        end else if (!dvld_q || word_acc) begin
                            dout_d  = word_w;
                            dvld_d  = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                            state_d = S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (word_acc) begin
                        dout_d  = shreg_q;
                        dvld_d  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = S_FILL;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
            shreg_q <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

    deser_bit_counter #(
        .MAX (LEN),
        .CW  (CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .count_o (bit_count)
    );

    assign data_out   = dout_q;
    assign data_valid = dvld_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: an MSB-first and an LSB-first LEN=8 deserializer driven from the same inputs.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       data_ready = 1'b0;

    logic       m_bit_ready, l_bit_ready;
    logic [7:0] m_data_out, l_data_out;
    logic       m_data_valid, l_data_valid;
    logic [3:0] m_bit_count, l_bit_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.LEN(8), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (m_bit_ready),
        .data_out   (m_data_out),
        .data_valid (m_data_valid),
        .data_ready (data_ready),
        .bit_count  (m_bit_count)
    );

    serial_deserializer #(.LEN(8), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (l_bit_ready),
        .data_out   (l_data_out),
        .data_valid (l_data_valid),
        .data_ready (data_ready),
        .bit_count  (l_bit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one bit for one rising edge; returns at the following falling edge.
    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] words [3];

        // Reset state
        #2;
        chk("rst_valid", {31'd0, m_data_valid}, 32'd0);
        chk("rst_ready", {31'd0, m_bit_ready}, 32'd0);
        chk("rst_count", {28'd0, m_bit_count}, 32'd0);
        chk("rst_dout", {24'd0, m_data_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        data_ready = 1'b1;

        // 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i > 0) begin
                chk("t1_lsb_count", {28'd0, l_bit_count}, 32'(8 - i));
                chk("t1_valid_early", {31'd0, m_data_valid}, 32'd0);
            end
        end
        bit_valid = 1'b0;
        chk("t1_msb_dout", {24'd0, m_data_out}, 32'hB2);
        chk("t1_msb_valid", {31'd0, m_data_valid}, 32'd1);
        chk("t1_lsb_dout", {24'd0, l_data_out}, 32'h4D);
        chk("t1_lsb_count_wrap", {28'd0, l_bit_count}, 32'd0);
        @(negedge clk);
        chk("t1_valid_one_cycle", {31'd0, m_data_valid}, 32'd0);
        chk("t1_dout_kept", {24'd0, m_data_out}, 32'hB2);

        // Backpressure: A5 held, 3C stalls in the shift register
        data_ready = 1'b0;
        send_byte(8'hA5);
        chk("t3_first_dout", {24'd0, m_data_out}, 32'hA5);
        send_byte(8'h3C);
        bit_valid = 1'b0;
        chk("t3_held_dout", {24'd0, m_data_out}, 32'hA5);
        chk("t3_held_valid", {31'd0, m_data_valid}, 32'd1);
        chk("t3_stall_ready", {31'd0, m_bit_ready}, 32'd0);
        chk("t3_stall_count", {28'd0, m_bit_count}, 32'd8);
        data_ready = 1'b1;
        @(negedge clk);
        chk("t3_second_dout", {24'd0, m_data_out}, 32'h3C);
        chk("t3_second_valid", {31'd0, m_data_valid}, 32'd1);
        chk("t3_ready_back", {31'd0, m_bit_ready}, 32'd1);
        chk("t3_count_zero", {28'd0, m_bit_count}, 32'd0);
        @(negedge clk);
        chk("t3_drained", {31'd0, m_data_valid}, 32'd0);

        // Continuous stream of three words with a ready consumer
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        for (int w = 0; w < 3; w++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(words[w][i]);
                chk("t4_bit_ready", {31'd0, m_bit_ready}, 32'd1);
                chk("t4_valid", {31'd0, m_data_valid}, (i == 0) ? 32'd1 : 32'd0);
                if (i == 0) chk("t4_dout", {24'd0, m_data_out}, {24'd0, words[w]});
            end
        end
        bit_valid = 1'b0;
        @(negedge clk);

        // clear drops the partial word and the coincident bit
        send_byte(8'hFF);
        bit_valid = 1'b0;
        @(negedge clk);
        pat = 8'b1010_1000;
        for (int i = 7; i >= 3; i--) send_bit(pat[i]);
        clear = 1'b1;
        send_bit(1'b0);
        clear = 1'b0;
        chk("t5_clear_count", {28'd0, m_bit_count}, 32'd0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("t5_no_early_word", {31'd0, m_data_valid}, 32'd0);
        send_bit(1'b1);
        bit_valid = 1'b0;
        chk("t5_dout_ff", {24'd0, m_data_out}, 32'hFF);
        chk("t5_valid_ff", {31'd0, m_data_valid}, 32'd1);
        @(negedge clk);

        // clear with a word pending, then clear releasing a stall
        data_ready = 1'b0;
        send_byte(8'h3C);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        chk("t5b_pending_dout", {24'd0, m_data_out}, 32'h3C);
        chk("t5b_pending_valid", {31'd0, m_data_valid}, 32'd1);
        chk("t5b_count", {28'd0, m_bit_count}, 32'd0);
        send_byte(8'h81);
        bit_valid = 1'b0;
        chk("t5b_stall_ready", {31'd0, m_bit_ready}, 32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t5b_release_ready", {31'd0, m_bit_ready}, 32'd1);
        chk("t5b_release_count", {28'd0, m_bit_count}, 32'd0);
        chk("t5b_release_dout", {24'd0, m_data_out}, 32'h3C);
        chk("t5b_release_valid", {31'd0, m_data_valid}, 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        chk("t5b_stalled_discarded", {31'd0, m_data_valid}, 32'd0);

        // Reset in the middle of a word and between edges
        data_ready = 1'b0;
        send_byte(8'h99);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bit_valid = 1'b0;
        chk("t6_pre_count", {28'd0, m_bit_count}, 32'd3);
        chk("t6_pre_valid", {31'd0, m_data_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, m_data_valid}, 32'd0);
        chk("t6_rst_dout", {24'd0, m_data_out}, 32'd0);
        chk("t6_rst_count", {28'd0, m_bit_count}, 32'd0);
        chk("t6_rst_ready", {31'd0, m_bit_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        data_ready = 1'b1;
        pat = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        chk("t6_no_residue", {31'd0, m_data_valid}, 32'd0);
        send_bit(pat[0]);
        bit_valid = 1'b0;
        chk("t6_dout_5a", {24'd0, m_data_out}, 32'h5A);
        chk("t6_valid_5a", {31'd0, m_data_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
